// File: rtl/core_pkg.sv
// Shared types for the fib core: machine word, fetch packet and PC step.
package core_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_pkt_t;

  localparam word_t PC_STEP = 32'd4;

  // Instruction fetch is word-aligned; byte-offset bits of a target are dropped.
  function automatic word_t align_pc(input word_t pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetch packets; storage is registered, no input-to-output bypass.
module fetch_fifo
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_pkt_t din,
  output fetch_pkt_t dout,
  output logic [1:0] count
);

  fetch_pkt_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, one-deep in-flight tracking and credit-based issue
// into a 2-entry output queue presented to decode over valid/ready.
module fetch_unit
  import core_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter int    IMEM_AW  = 12
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_instr
);

  word_t      pc_p0;
  logic       vld_p1;
  word_t      tag_p1;
  logic [1:0] count;
  logic [2:0] credits_used;
  logic       pop;
  logic       push;
  fetch_pkt_t push_pkt;
  fetch_pkt_t head_pkt;

  // A slot freed by this cycle's pop can be reused by this cycle's issue.
  assign credits_used = {1'b0, count} + {2'b00, vld_p1};
  assign out_valid    = !rst && !redirect_valid && (count != 2'd0);
  assign pop          = out_valid && out_ready;
  assign imem_en      = !rst && !redirect_valid && ((credits_used < 3'd2) || pop);
  assign imem_addr    = pc_p0[IMEM_AW+1:2];

  // ---- stage p0: PC and issue ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0  <= RESET_PC;
      vld_p1 <= 1'b0;
    end else if (redirect_valid) begin
      pc_p0  <= align_pc(redirect_pc);
      vld_p1 <= 1'b0;
    end else begin
      if (imem_en) pc_p0 <= pc_p0 + PC_STEP;
      vld_p1 <= imem_en;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_en) tag_p1 <= pc_p0;
  end

  // ---- stage p1: memory response joins its tag and enters the queue ----
  assign push           = vld_p1 && !redirect_valid && !rst;
  assign push_pkt.pc    = tag_p1;
  assign push_pkt.instr = imem_rdata;

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_pkt),
    .dout  (head_pkt),
    .count (count)
  );

  assign out_pc    = head_pkt.pc;
  assign out_instr = head_pkt.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed per-cycle vectors for fetch_unit with a 1-cycle imem model returning word = addr.
module tb_fetch_unit;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'd0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;

  int tests = 0;
  int fails = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'(imem_addr);
  end

  typedef struct packed {
    logic          rst;
    logic          rv;
    logic [31:0]   rpc;
    logic          rdy;
    logic          en;
    logic [AW-1:0] addr;
    logic          vld;
    logic [31:0]   pc;
    logic [31:0]   instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic en, input logic [AW-1:0] addr,
                              input logic vld, input logic [31:0] pc, input logic [31:0] instr);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.en = en; v.addr = addr; v.vld = vld; v.pc = pc; v.instr = instr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    //                 rst rv rpc           rdy en addr     vld pc            instr
    vecs.push_back(mk(1, 0, 32'h0,         1, 0, 12'h000, 0, 32'h0,         32'h0));   // 0 reset
    vecs.push_back(mk(1, 0, 32'h0,         1, 0, 12'h000, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h000, 0, 32'h0,         32'h0));   // 2 first issue
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h001, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h002, 1, 32'h0,         32'h0));   // 4 first valid
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h003, 1, 32'h4,         32'h1));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h004, 1, 32'h8,         32'h2));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h005, 1, 32'hC,         32'h3));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 12'h000, 0, 32'h0,         32'h0));   // 8 reset, backpressure run
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 12'h000, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 12'h001, 0, 32'h0,         32'h0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0, 0, 32'h0,       0, 0, 12'h000, 1, 32'h0,         32'h0));   // 11-16 held
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h002, 1, 32'h0,         32'h0));   // 17 release
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h003, 1, 32'h4,         32'h1));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h004, 1, 32'h8,         32'h2));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 12'h000, 1, 32'hC,         32'h3));   // 20 fill queue
    vecs.push_back(mk(0, 1, 32'h0000_0103, 1, 0, 12'h000, 0, 32'h0,         32'h0));   // 21 redirect, ready=1
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h040, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h041, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h042, 1, 32'h100,       32'h40));  // 24 target valid
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h043, 1, 32'h104,       32'h41));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 1, 0, 12'h000, 0, 32'h0,         32'h0));   // 26 redirect w/ inflight
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'hFFF, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h000, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h001, 1, 32'hFFFF_FFFC, 32'hFFF));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h002, 1, 32'h0,         32'h0));   // 30 pc wrap
    vecs.push_back(mk(0, 1, 32'h0000_0200, 1, 0, 12'h000, 0, 32'h0,         32'h0));   // 31 back-to-back
    vecs.push_back(mk(0, 1, 32'h0000_0300, 1, 0, 12'h000, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h0C0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h0C1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h0C2, 1, 32'h300,       32'hC0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 12'h000, 1, 32'h304,       32'hC1));  // 36 fill queue
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 12'h000, 1, 32'h304,       32'hC1));
    vecs.push_back(mk(1, 0, 32'h0,         1, 0, 12'h000, 0, 32'h0,         32'h0));   // 38 mid-stream reset
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h000, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h001, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 12'h002, 1, 32'h0,         32'h0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst            = vecs[i].rst;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
      #1;
      check($sformatf("row%0d imem_en", i), 32'(imem_en), 32'(vecs[i].en));
      if (vecs[i].en)
        check($sformatf("row%0d imem_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].vld));
      if (vecs[i].vld) begin
        check($sformatf("row%0d out_pc", i), out_pc, vecs[i].pc);
        check($sformatf("row%0d out_instr", i), out_instr, vecs[i].instr);
      end
    end

    // Redirect under streaming: target shows up exactly three cycles later, then streams.
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0082;
    out_ready      = 1'b1;
    #1;
    check("seq redirect out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    n = 1;
    #1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
      #1;
    end
    check("seq redirect latency", n, 3);
    check("seq redirect pc", out_pc, 32'h80);
    check("seq redirect instr", out_instr, 32'h20);
    @(negedge clk);
    #1;
    check("seq next valid", 32'(out_valid), 32'd1);
    check("seq next pc", out_pc, 32'h84);
    check("seq next instr", out_instr, 32'h21);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
